gcn_transform_fsm: RTL and testbench
====================================

# gcn_transform_fsm

Controller that sequences the feature-by-weight transformation stage of the GCN accelerator. On `start` it streams the WEIGHT_COLS weight columns from the shared read port into the weight buffer. It then walks every feature row: it loads the row into the scratch pad and issues one product-write per weight column. It raises `done_trans` when the full FEATURE_ROWS x WEIGHT_COLS product matrix is written. It sits between the top-level GCN sequencer and the transformation datapath (weight buffer, scratch pad, dot-product unit, product buffer).

## Interface
- FEATURE_ROWS, 6, number of feature rows (graph nodes)
- WEIGHT_COLS, 3, number of weight columns
- ADDRESS_WIDTH, 13, read address width
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), row counter width
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- start  in  1  level request; sampled only in IDLE
- enable_read  out  1  read strobe to the shared feature/weight memory
- read_address  out  ADDRESS_WIDTH  weight column j at address j; feature row r at FEATURE_BASE + r
- enable_write_weight  out  1  weight buffer captures data_in into column weight_count
- enable_scratch_pad  out  1  scratch pad captures data_in as the current feature row
- enable_write_fm_wm_prod  out  1  product buffer writes dot(scratch pad, weight column weight_count) at [feature_count][weight_count]
- weight_count  out  COUNTER_WEIGHT_WIDTH  current weight column index
- feature_count  out  COUNTER_FEATURE_WIDTH  current feature row index
- done_trans  out  1  transformation complete

## Operation
- States: IDLE, READ_WEIGHTS, READ_FEATURE, COMPUTE, DONE.
- Outputs are a Moore decode of the registered state and counters. No output depends combinationally on `start`.
- IDLE:
  - All outputs are 0 and both counters are 0.
  - `start`=1 -> READ_WEIGHTS.
- READ_WEIGHTS:
  - Drives enable_read=1, read_address=weight_count and enable_write_weight=1.
  - weight_count increments each cycle.
  - At WEIGHT_COLS-1, weight_count wraps to 0 and the state goes to READ_FEATURE.
- READ_FEATURE:
  - Lasts one cycle.
  - Drives enable_read=1, read_address=FEATURE_BASE+feature_count and enable_scratch_pad=1.
  - Next state is COMPUTE.
- COMPUTE:
  - Drives enable_write_fm_wm_prod=1 and enable_read=0.
  - weight_count steps 0..WEIGHT_COLS-1, then wraps to 0.
  - On the last column: if feature_count==FEATURE_ROWS-1, go to DONE. Otherwise increment feature_count and go to READ_FEATURE.
- DONE:
  - done_trans=1 and all enables are 0.
  - Counters hold at 0.
  - Stays in DONE while start=1. start=0 -> IDLE.
- Memory data is combinational on read_address. The datapath captures data_in at the same rising edge that ends the strobe cycle.
- read_address is 0 whenever enable_read=0.
- Counters never exceed their limits. Non-power-of-two limits wrap explicitly; they do not roll over at the counter width.

## Timing
- Reset (async): state=IDLE, both counters 0, every output 0 (including read_address and done_trans), effective immediately without a clock edge.
- Let edge E0 be the edge that samples start=1 in IDLE:
  - Weights are read in cycles 1..WEIGHT_COLS.
  - Each row then takes 1+WEIGHT_COLS cycles.
  - done_trans first goes high in cycle WEIGHT_COLS + FEATURE_ROWS*(1+WEIGHT_COLS) + 1. With the defaults this is cycle 28.
- start dropping mid-run is ignored; the run completes.
- start held high through DONE does not retrigger. A new run needs start=0 (return to IDLE), then start=1.
- Reset asserted mid-run aborts the run. Buffer contents are undefined; the next start begins again from weight column 0.

## Structure
- Shared package gcn_pkg:
  - state enum (IDLE, READ_WEIGHTS, READ_FEATURE, COMPUTE, DONE)
  - FEATURE_BASE = 13'h200
- Sub-module gcn_mod_counter:
  - parameterized modulo-N counter with enable, synchronous clear and async reset
  - provides terminal-count output
  - instantiated twice, for weight_count and feature_count.

## Test plan
- Default parameters, start pulsed high for 1 cycle:
  - read_address sequence 0,1,2, then 0x200, then 0x201 four cycles later, ... up to 0x205.
  - Exactly 18 enable_write_fm_wm_prod cycles.
  - done_trans high at cycle 28.
- Per-row check:
  - For each feature_count r, exactly one enable_scratch_pad cycle, followed by writes with weight_count 0,1,2.
  - enable_read=0 during every COMPUTE cycle.
- start held high through DONE for 10 cycles:
  - No new reads; done_trans stays 1.
  - start=0 -> IDLE and done_trans=0 next cycle.
  - start=1 again -> a second identical 28-cycle run.
- reset asserted asynchronously (mid-cycle) while in COMPUTE with feature_count=3:
  - All outputs 0 immediately.
  - After release, the next start restarts at read_address 0.
- start toggled low/high during READ_WEIGHTS and COMPUTE: sequence unchanged, done_trans still at cycle 28.
- Parameter sweep FEATURE_ROWS=5, WEIGHT_COLS=4:
  - Counters wrap at 4 and 5 (not at a power of two).
  - done_trans at cycle 4 + 5*5 + 1 = 30.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared types and constants for the GCN transformation stage.
package gcn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WEIGHTS,
    READ_FEATURE,
    COMPUTE,
    DONE
  } state_t;

  // Feature rows live above the weight columns in the shared read space.
  localparam logic [12:0] FEATURE_BASE = 13'h200;

endpackage

// File: rtl/gcn_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and terminal-count flag.
module gcn_mod_counter #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc    = (count_q == W'(N - 1));
  assign count = count_q;

  // Wrap explicitly at N-1 so non-power-of-two limits never overrun.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcn_transform_fsm.sv
// Sequences weight load, per-row feature load and product writes for the
// feature-by-weight transformation stage.
module gcn_transform_fsm
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             enable_read,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             enable_write_weight,
  output logic                             enable_scratch_pad,
  output logic                             enable_write_fm_wm_prod,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
  output logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
  output logic                             done_trans
);

  state_t state_q;
  state_t state_d;

  logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_cnt;
  logic [COUNTER_FEATURE_WIDTH-1:0] feature_cnt;
  logic weight_tc;
  logic feature_tc;
  logic weight_en;
  logic feature_en;
  logic cnt_clr;

  assign weight_en  = (state_q == READ_WEIGHTS) || (state_q == COMPUTE);
  // The row counter also advances on the final row so it lands back on 0 for DONE.
  assign feature_en = (state_q == COMPUTE) && weight_tc;
  assign cnt_clr    = (state_q == IDLE) || (state_q == DONE);

  gcn_mod_counter #(
    .N (WEIGHT_COLS),
    .W (COUNTER_WEIGHT_WIDTH)
  ) u_weight_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (weight_en),
    .clr   (cnt_clr),
    .count (weight_cnt),
    .tc    (weight_tc)
  );

  gcn_mod_counter #(
    .N (FEATURE_ROWS),
    .W (COUNTER_FEATURE_WIDTH)
  ) u_feature_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (feature_en),
    .clr   (cnt_clr),
    .count (feature_cnt),
    .tc    (feature_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (start) state_d = READ_WEIGHTS;
      READ_WEIGHTS: if (weight_tc) state_d = READ_FEATURE;
      READ_FEATURE: state_d = COMPUTE;
      COMPUTE:      if (weight_tc) state_d = feature_tc ? DONE : READ_FEATURE;
      DONE:         if (!start) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_read             = 1'b0;
    read_address            = '0;
    enable_write_weight     = 1'b0;
    enable_scratch_pad      = 1'b0;
    enable_write_fm_wm_prod = 1'b0;
    done_trans              = 1'b0;
    weight_count            = weight_cnt;
    feature_count           = feature_cnt;
    unique case (state_q)
      READ_WEIGHTS: begin
        enable_read         = 1'b1;
        read_address        = ADDRESS_WIDTH'(weight_cnt);
        enable_write_weight = 1'b1;
      end
      READ_FEATURE: begin
        enable_read        = 1'b1;
        read_address       = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(feature_cnt);
        enable_scratch_pad = 1'b1;
      end
      COMPUTE: enable_write_fm_wm_prod = 1'b1;
      DONE:    done_trans = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcn_transform_fsm.sv
// Scoreboard bench: expected transactions are queued at stimulus time and a
// negedge monitor per DUT pops and compares every active output cycle.
module tb_gcn_transform_fsm;

  typedef struct packed {
    logic        rd;
    logic [12:0] addr;
    logic        ww;
    logic        sp;
    logic        pw;
    logic [2:0]  wc;
    logic [2:0]  fc;
    logic        done;
    int          cyc;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        rd_a, ww_a, sp_a, pw_a, done_a;
  logic [12:0] addr_a;
  logic [1:0]  wc_a;
  logic [2:0]  fc_a;
  logic        rd_b, ww_b, sp_b, pw_b, done_b;
  logic [12:0] addr_b;
  logic [1:0]  wc_b;
  logic [2:0]  fc_b;

  txn_t q0[$];
  txn_t q1[$];
  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int e0[2] = '{0, 0};
  int done_cyc[2] = '{-1, -1};
  int wr_cnt[2] = '{0, 0};
  logic done_prev_a = 1'b0;
  logic done_prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  gcn_transform_fsm dut_a (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start_a),
    .enable_read             (rd_a),
    .read_address            (addr_a),
    .enable_write_weight     (ww_a),
    .enable_scratch_pad      (sp_a),
    .enable_write_fm_wm_prod (pw_a),
    .weight_count            (wc_a),
    .feature_count           (fc_a),
    .done_trans              (done_a)
  );

  gcn_transform_fsm #(.FEATURE_ROWS(5), .WEIGHT_COLS(4)) dut_b (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start_b),
    .enable_read             (rd_b),
    .read_address            (addr_b),
    .enable_write_weight     (ww_b),
    .enable_scratch_pad      (sp_b),
    .enable_write_fm_wm_prod (pw_b),
    .weight_count            (wc_b),
    .feature_count           (fc_b),
    .done_trans              (done_b)
  );

  function automatic int qsize(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start_a = v;
    else start_b = v;
  endtask

  task automatic push_exp(input int inst, input txn_t e, input int max_cyc);
    if (e.cyc <= max_cyc) begin
      if (inst == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Expected cycle-by-cycle activity of one run, cycle 1 following the start edge.
  task automatic push_run(input int inst, input int fr, input int wcn, input int max_cyc);
    txn_t e;
    int c = 1;
    for (int j = 0; j < wcn; j++) begin
      e = '0; e.rd = 1'b1; e.addr = 13'(j); e.ww = 1'b1; e.wc = 3'(j); e.cyc = c;
      push_exp(inst, e, max_cyc); c++;
    end
    for (int r = 0; r < fr; r++) begin
      e = '0; e.rd = 1'b1; e.addr = 13'h200 + 13'(r); e.sp = 1'b1; e.fc = 3'(r); e.cyc = c;
      push_exp(inst, e, max_cyc); c++;
      for (int j = 0; j < wcn; j++) begin
        e = '0; e.pw = 1'b1; e.wc = 3'(j); e.fc = 3'(r); e.cyc = c;
        push_exp(inst, e, max_cyc); c++;
      end
    end
    e = '0; e.done = 1'b1; e.cyc = c;
    push_exp(inst, e, max_cyc);
  endtask

  task automatic check_obs(input int inst, input txn_t o);
    txn_t e;
    if (o.done) done_cyc[inst] = o.cyc;
    if (o.pw) wr_cnt[inst]++;
    vectors++;
    if (qsize(inst) == 0) begin
      miscompares++;
      $display("FAIL unexpected_txn inst=%0d cyc=%0d rd=%0b addr=%h pw=%0b done=%0b required none",
               inst, o.cyc, o.rd, o.addr, o.pw, o.done);
    end else begin
      e = (inst == 0) ? q0.pop_front() : q1.pop_front();
      if (o !== e) begin
        miscompares++;
        $display("FAIL txn inst=%0d got cyc=%0d rd=%0b addr=%h ww=%0b sp=%0b pw=%0b wc=%0d fc=%0d done=%0b required cyc=%0d rd=%0b addr=%h ww=%0b sp=%0b pw=%0b wc=%0d fc=%0d done=%0b",
                 inst, o.cyc, o.rd, o.addr, o.ww, o.sp, o.pw, o.wc, o.fc, o.done,
                 e.cyc, e.rd, e.addr, e.ww, e.sp, e.pw, e.wc, e.fc, e.done);
      end else begin
        $display("txn inst=%0d cyc=%0d rd=%0b addr=%h ww=%0b sp=%0b pw=%0b wc=%0d fc=%0d done=%0b ok",
                 inst, o.cyc, o.rd, o.addr, o.ww, o.sp, o.pw, o.wc, o.fc, o.done);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    txn_t o;
    o = '0;
    o.rd = rd_a; o.addr = addr_a; o.ww = ww_a; o.sp = sp_a; o.pw = pw_a;
    o.wc = {1'b0, wc_a}; o.fc = fc_a; o.done = done_a;
    o.cyc = edge_cnt - e0[0] + 1;
    if (o.rd || o.ww || o.sp || o.pw || (o.done && !done_prev_a)) check_obs(0, o);
    done_prev_a <= done_a;
  end

  always @(negedge clk) begin
    txn_t o;
    o = '0;
    o.rd = rd_b; o.addr = addr_b; o.ww = ww_b; o.sp = sp_b; o.pw = pw_b;
    o.wc = {1'b0, wc_b}; o.fc = fc_b; o.done = done_b;
    o.cyc = edge_cnt - e0[1] + 1;
    if (o.rd || o.ww || o.sp || o.pw || (o.done && !done_prev_b)) check_obs(1, o);
    done_prev_b <= done_b;
  end

  task automatic pulse_start(input int inst);
    set_start(inst, 1'b0);
    repeat (2) @(negedge clk);
    wr_cnt[inst] = 0;
    done_cyc[inst] = -1;
    set_start(inst, 1'b1);
    @(posedge clk);
    #1 e0[inst] = edge_cnt;
    @(negedge clk);
    set_start(inst, 1'b0);
  endtask

  task automatic do_run(input int inst, input int fr, input int wcn, input bit toggle,
                        input int exp_done, input int exp_wr);
    int c;
    push_run(inst, fr, wcn, 1000);
    pulse_start(inst);
    for (int k = 0; k < 200 && qsize(inst) != 0; k++) begin
      @(negedge clk);
      #1;
      c = edge_cnt - e0[inst] + 1;
      if (toggle)
        set_start(inst, ((c >= 1 && c <= 3) || (c >= 5 && c <= 7) || (c >= 17 && c <= 19)) ? c[0] : 1'b0);
    end
    chk("run_timeout_pending", 32'(qsize(inst)), 32'd0);
    chk("done_cycle", 32'(done_cyc[inst]), 32'(exp_done));
    chk("product_writes", 32'(wr_cnt[inst]), 32'(exp_wr));
  endtask

  initial begin
    int c;
    #1;
    chk("reset_outputs_a", {12'd0, rd_a, addr_a, ww_a, sp_a, pw_a, wc_a, fc_a, done_a}, 32'd0);
    chk("reset_outputs_b", {12'd0, rd_b, addr_b, ww_b, sp_b, pw_b, wc_b, fc_b, done_b}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Baseline run, then start held through DONE.
    do_run(0, 6, 3, 1'b0, 28, 18);
    set_start(0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("hold_done", 32'(done_a), 32'd1);
      chk("hold_no_read", 32'(rd_a), 32'd0);
    end
    set_start(0, 1'b0);
    @(posedge clk);
    #1 chk("idle_after_drop", 32'(done_a), 32'd0);

    do_run(0, 6, 3, 1'b0, 28, 18);

    // Abort mid-COMPUTE of row 3 with an asynchronous reset.
    push_run(0, 6, 3, 18);
    pulse_start(0);
    for (int k = 0; k < 40; k++) begin
      c = edge_cnt - e0[0] + 1;
      if (c >= 18) break;
      @(negedge clk);
      #1;
    end
    chk("abort_fc", 32'(fc_a), 32'd3);
    chk("abort_in_compute", 32'(pw_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_outputs_zero", {12'd0, rd_a, addr_a, ww_a, sp_a, pw_a, wc_a, fc_a, done_a}, 32'd0);
    chk("abort_pending", 32'(q0.size()), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_run(0, 6, 3, 1'b0, 28, 18);

    // start wiggled while busy must not disturb the run.
    do_run(0, 6, 3, 1'b1, 28, 18);

    // Non-power-of-two geometry.
    do_run(1, 5, 4, 1'b0, 30, 20);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
